// File: rtl/avalon_st_pixel_source.sv
// avalon_st_pixel_source
//   Transmit side of the filter datapath. Filtered pixels arrive on a
//   valid/w strobe that cannot be stalled. They are buffered in a small FIFO
//   and leave as an Avalon-ST source with ready/valid backpressure. Every
//   outgoing beat is tagged with frame-level start/end-of-packet markers.
//
// Ports
//   clk             in   rising-edge clock for all logic
//   reset           in   asynchronous active-high reset, clears all state
//   valid           in   input pixel strobe
//   w               in   input pixel, sampled when valid=1
//   clear_overflow  in   synchronous clear of the sticky overflow flag
//   almost_full     out  FIFO occupancy >= ALMOST_FULL_LEVEL
//   overflow        out  sticky: an input pixel was dropped on a full FIFO
//   src_data        out  head-of-FIFO pixel (show-ahead)
//   src_valid       out  src_data is valid (FIFO not empty)
//   src_ready       in   sink accepts the current beat
//   src_sop         out  current beat is pixel (0,0) of a frame
//   src_eop         out  current beat is the last pixel of a frame
//   frame_done      out  one-cycle pulse after the eop beat is accepted
module avalon_st_pixel_source #(
  parameter int FP_WORD_LENGTH    = 32,
  parameter int ADDR_WIDTH        = 4,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int FRAME_WIDTH       = 640,
  parameter int FRAME_HEIGHT      = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  input  logic [FP_WORD_LENGTH-1:0] w,
  input  logic                      clear_overflow,
  output logic                      almost_full,
  output logic                      overflow,
  output logic [FP_WORD_LENGTH-1:0] src_data,
  output logic                      src_valid,
  input  logic                      src_ready,
  output logic                      src_sop,
  output logic                      src_eop,
  output logic                      frame_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int COL_W = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [COL_W-1:0]    COL_LAST = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);

  logic [FP_WORD_LENGTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]     r_wr_ptr;
  logic [ADDR_WIDTH-1:0]     r_rd_ptr;
  logic [ADDR_WIDTH:0]       r_count;
  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic                      r_overflow;
  logic                      r_frame_done;

  logic w_full;
  logic w_wr;
  logic w_drop;
  logic w_beat;
  logic w_col_last;
  logic w_row_last;

  // A full FIFO refuses the write even if a beat frees a slot on the same
  // edge; this keeps the full/drop decision independent of src_ready.
  assign w_full     = (r_count == FULL_CNT);
  assign w_wr       = valid & ~w_full;
  assign w_drop     = valid &  w_full;
  assign w_beat     = src_valid & src_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // Show-ahead outputs: the head entry is always visible, so data and
  // markers stay stable for as long as the sink stalls.
  assign src_valid   = (r_count != '0);
  assign src_data    = r_mem[r_rd_ptr];
  assign src_sop     = src_valid & (r_col == '0) & (r_row == '0);
  assign src_eop     = src_valid & w_col_last & w_row_last;
  assign almost_full = (r_count >= AF_CNT);
  assign overflow    = r_overflow;
  assign frame_done  = r_frame_done;

  // Pixel storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_beat) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_beat})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame position: advances on accepted beats only, so dropped input
  // pixels shift the outgoing frame rather than leaving holes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_beat & src_eop;
      if (w_beat) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avalon_st_pixel_source.sv
module tb_avalon_st_pixel_source;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int TH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] w = '0;
  logic          clear_overflow = 1'b0;
  logic          almost_full;
  logic          overflow;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready = 1'b0;
  logic          src_sop;
  logic          src_eop;
  logic          frame_done;

  int n_pass = 0;
  int n_total = 0;

  logic [DW-1:0] q[$];
  int  mbeat = 0;
  logic exp_fd = 1'b0;

  avalon_st_pixel_source #(
    .FP_WORD_LENGTH(DW), .ADDR_WIDTH(4), .ALMOST_FULL_LEVEL(12),
    .FRAME_WIDTH(TW), .FRAME_HEIGHT(TH)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .w(w),
    .clear_overflow(clear_overflow), .almost_full(almost_full),
    .overflow(overflow), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compares every accepted beat against the scoreboard queue and
  // a beat-index model of the frame position.
  always @(negedge clk) begin
    if (reset) begin
      mbeat  = 0;
      exp_fd = 1'b0;
    end else begin
      check("frame_done", {31'b0, frame_done}, {31'b0, exp_fd});
      exp_fd = 1'b0;
      if (src_valid && src_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", src_data, 32'hDEAD_BEEF);
        end else begin
          logic [DW-1:0] e;
          logic es, ee;
          e  = q.pop_front();
          es = ((mbeat % TW) == 0) && (((mbeat / TW) % TH) == 0);
          ee = ((mbeat % TW) == TW-1) && (((mbeat / TW) % TH) == TH-1);
          check("beat_data", src_data, e);
          check("beat_sop", {31'b0, src_sop}, {31'b0, es});
          check("beat_eop", {31'b0, src_eop}, {31'b0, ee});
          exp_fd = ee;
          mbeat++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d, input bit push);
    valid = 1'b1;
    w = d;
    if (push) q.push_back(d);
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    valid = 1'b0;
    src_ready = 1'b1;
    n = 0;
    while (src_valid && n < budget) begin
      tick();
      n++;
    end
    if (src_valid) check("drain_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic do_reset();
    valid = 1'b0;
    src_ready = 1'b0;
    reset = 1'b1;
    q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      valid = 1'($urandom);
      w = $urandom;
      src_ready = 1'($urandom);
      clear_overflow = 1'($urandom);
      tick();
      check("rst_valid", {31'b0, src_valid}, 32'd0);
      check("rst_ovf", {31'b0, overflow}, 32'd0);
      check("rst_af", {31'b0, almost_full}, 32'd0);
    end
    valid = 1'b0;
    src_ready = 1'b0;
    clear_overflow = 1'b0;
    reset = 1'b0;
    tick();
    check("post_rst_valid", {31'b0, src_valid}, 32'd0);
    check("post_rst_ovf", {31'b0, overflow}, 32'd0);
    check("post_rst_af", {31'b0, almost_full}, 32'd0);

    // 2: pass-through, each pixel visible right after its write edge
    src_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(DW'(i), 1'b1);
      check("pt_valid", {31'b0, src_valid}, 32'd1);
      check("pt_data", src_data, DW'(i));
    end
    drain(20);

    // 3: backpressure, almost_full boundary, held head
    src_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      put(32'h100 + DW'(i), 1'b1);
      if (i == 10) check("af_at_11", {31'b0, almost_full}, 32'd0);
    end
    valid = 1'b0;
    check("af_at_12", {31'b0, almost_full}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", src_data, 32'h100);
      check("bp_hold_valid", {31'b0, src_valid}, 32'd1);
    end
    drain(40);

    // 4: overflow on the 17th write, then clear
    src_ready = 1'b0;
    for (int i = 0; i < 16; i++) put(32'h200 + DW'(i), 1'b1);
    check("full_no_ovf", {31'b0, overflow}, 32'd0);
    put(32'h2FF, 1'b0);
    valid = 1'b0;
    check("ovf_set", {31'b0, overflow}, 32'd1);
    check("ovf_head", src_data, 32'h200);
    valid = 1'b1;
    w = 32'h2EE;
    clear_overflow = 1'b1;
    tick();
    valid = 1'b0;
    check("ovf_set_wins", {31'b0, overflow}, 32'd1);
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", {31'b0, overflow}, 32'd0);
    drain(40);

    // 5: frame markers over two frames, aligned from reset
    do_reset();
    src_ready = 1'b1;
    for (int i = 0; i < 16; i++) put(32'h300 + DW'(i), 1'b1);
    drain(20);
    tick();

    // 6: mid-frame reset with three pixels queued
    do_reset();
    src_ready = 1'b1;
    for (int i = 0; i < 5; i++) put(32'h400 + DW'(i), 1'b1);
    valid = 1'b0;
    tick();
    src_ready = 1'b0;
    for (int i = 0; i < 3; i++) put(32'h410 + DW'(i), 1'b1);
    valid = 1'b0;
    check("mf_queued", {31'b0, src_valid}, 32'd1);
    reset = 1'b1;
    q.delete();
    tick();
    check("mf_rst_empty", {31'b0, src_valid}, 32'd0);
    reset = 1'b0;
    tick();
    check("mf_after_empty", {31'b0, src_valid}, 32'd0);
    put(32'h4AA, 1'b1);
    valid = 1'b0;
    check("mf_sop", {31'b0, src_sop}, 32'd1);
    check("mf_data", src_data, 32'h4AA);
    drain(10);

    tick();
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
